// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - show-ahead synchronous FIFO with occupancy level
//
// Ports:
//   clk, rst     clock; synchronous active-high reset (empties the FIFO)
//   push         write request; push_data is stored when push_ok is high
//   push_data    entry to write
//   push_ok      push accepted this cycle (not full, or a pop happens alongside)
//   pop          read request; ignored while empty
//   head_data    oldest entry, valid while valid is high
//   valid        FIFO non-empty
//   level        entries currently stored, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       push_ok,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       valid,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_pop;
    logic             do_push;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_pop    = pop & (count != '0);
    assign do_push   = push & ((count != LW'(DEPTH)) | do_pop);
    assign push_ok   = do_push;
    assign valid     = (count != '0);
    assign level     = count;
    assign head_data = mem[rd_ptr];

    // Storage is left unreset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/sample_pack_fifo.sv
// rtl/sample_pack_fifo.sv - pairs sampled 32-bit words into 64-bit FIFO entries
//
// Ports:
//   clk2, rst    fast clock; synchronous active-high reset
//   in_data      sampled word, qualified by the single-cycle in_en pulse
//   out_data     FIFO head {high word, low word}
//   out_half     head holds only a low word (high word is zero)
//   out_valid    FIFO non-empty; out_ready pops the head
//   level        entries currently stored
//   overflow     sticky drop flag, cleared by ovf_clr (a new drop wins)
module sample_pack_fifo #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 63
) (
    input  logic                   clk2,
    input  logic                   rst,
    input  logic [31:0]            in_data,
    input  logic                   in_en,
    output logic [63:0]            out_data,
    output logic                   out_half,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    input  logic                   ovf_clr
);
    localparam logic ST_EMPTY = 1'b0;
    localparam logic ST_LOW   = 1'b1;

    logic        state;
    logic        state_nxt;
    logic [31:0] low_word;
    logic [7:0]  timer;
    logic        push;
    logic [64:0] push_data;
    logic        push_ok;
    logic [64:0] head;
    logic        fifo_valid;

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_data = '0;
        case (state)
            ST_EMPTY: begin
                if (in_en) begin
                    state_nxt = ST_LOW;
                end
            end
            default: begin
                // A word arriving on the timeout cycle wins: pair, don't flush.
                if (in_en) begin
                    push      = 1'b1;
                    push_data = {1'b0, in_data, low_word};
                    state_nxt = ST_EMPTY;
                end else if (timer == 8'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    push_data = {1'b1, 32'h0, low_word};
                    state_nxt = ST_EMPTY;
                end
            end
        endcase
    end

    // The FSM returns to EMPTY whether or not the FIFO took the entry.
    always_ff @(posedge clk2) begin
        if (rst) begin
            state    <= ST_EMPTY;
            timer    <= '0;
            low_word <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_EMPTY) begin
                timer <= '0;
                if (in_en) begin
                    low_word <= in_data;
                end
            end else if (timer != 8'hFF) begin
                timer <= timer + 1'b1;
            end
        end
    end

    always_ff @(posedge clk2) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push & ~push_ok) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (65),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk2),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .push_ok   (push_ok),
        .pop       (out_ready),
        .head_data (head),
        .valid     (fifo_valid),
        .level     (level)
    );

    assign out_valid = fifo_valid;
    assign out_data  = head[63:0];
    assign out_half  = fifo_valid & head[64];
endmodule

// File: tb/tb_sample_pack_fifo.sv
// tb/tb_sample_pack_fifo.sv - randomized self-checking bench for sample_pack_fifo
module tb_sample_pack_fifo;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 63;
    localparam int LW      = $clog2(DEPTH) + 1;

    logic          clk2;
    logic          rst;
    logic [31:0]   in_data;
    logic          in_en;
    logic [63:0]   out_data;
    logic          out_half;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          ovf_clr;

    sample_pack_fifo #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk2      (clk2),
        .rst       (rst),
        .in_data   (in_data),
        .in_en     (in_en),
        .out_data  (out_data),
        .out_half  (out_half),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk2 = 1'b0;
    always #5 clk2 = ~clk2;

    typedef struct {
        bit          half;
        logic [63:0] data;
    } entry_t;

    entry_t      mq[$];
    bit          m_ovf;
    bit          m_pend;
    logic [31:0] m_low;
    int          m_pend_at;
    int          cyc;
    bit          armed;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_all();
        chk("valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("level", 64'(level), 64'(mq.size()));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (mq.size() != 0) begin
            chk("data", out_data, mq[0].data);
            chk("half", 64'(out_half), 64'(mq[0].half));
        end
    endtask

    // Reference: a word waits for a partner; if none arrives within TIMEOUT
    // cycles of its own arrival it leaves alone. Entries go into a bounded queue.
    task automatic model_step(input bit r, input bit en, input logic [31:0] d,
                              input bit rdy, input bit clr);
        bit     have;
        bit     pop;
        bit     room;
        entry_t e;
        have = 1'b0;
        e.half = 1'b0;
        e.data = '0;
        if (r) begin
            mq.delete();
            m_pend = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        if (!m_pend) begin
            if (en) begin
                m_pend    = 1'b1;
                m_low     = d;
                m_pend_at = cyc;
            end
        end else if (en) begin
            have   = 1'b1;
            e.data = {d, m_low};
            m_pend = 1'b0;
        end else if (cyc - m_pend_at == TIMEOUT) begin
            have   = 1'b1;
            e.half = 1'b1;
            e.data = {32'h0, m_low};
            m_pend = 1'b0;
        end
        pop  = (mq.size() != 0) && rdy;
        room = (mq.size() < DEPTH) || pop;
        if (pop) void'(mq.pop_front());
        if (have && room) mq.push_back(e);
        if (have && !room) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic tick(input bit r, input bit en, input logic [31:0] d,
                        input bit rdy, input bit clr);
        @(negedge clk2);
        if (armed) check_all();
        rst       = r;
        in_en     = en;
        in_data   = d;
        out_ready = rdy;
        ovf_clr   = clr;
        model_step(r, en, d, rdy, clr);
        cyc++;
        if (r) armed = 1'b1;
    endtask

    task automatic peek();
        @(posedge clk2);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc = 0;
        armed = 1'b0;
        m_pend = 1'b0;
        m_ovf = 1'b0;
        m_low = '0;
        m_pend_at = 0;
        rst = 1'b1;
        in_en = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;

        tick(1, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0);
        peek();
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_level", 64'(level), 64'd0);
        chk("reset_half", 64'(out_half), 64'd0);
        chk("reset_ovf", 64'(overflow), 64'd0);

        // Pair two words three cycles apart.
        tick(0, 1, 32'hA, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 1, 0);
        tick(0, 1, 32'hB, 1, 0);
        peek();
        chk("pair_valid", 64'(out_valid), 64'd1);
        chk("pair_data", out_data, 64'h0000000B_0000000A);
        chk("pair_half", 64'(out_half), 64'd0);
        tick(0, 0, 0, 1, 0);
        peek();
        chk("pair_one_cycle", 64'(out_valid), 64'd0);

        // Lone word flushes as a half entry after TIMEOUT cycles.
        tick(0, 1, 32'h5, 0, 0);
        repeat (TIMEOUT - 1) tick(0, 0, 0, 0, 0);
        peek();
        chk("tmo_not_yet", 64'(out_valid), 64'd0);
        tick(0, 0, 0, 0, 0);
        peek();
        chk("tmo_valid", 64'(out_valid), 64'd1);
        chk("tmo_data", out_data, 64'h0000_0000_0000_0005);
        chk("tmo_half", 64'(out_half), 64'd1);
        tick(0, 0, 0, 1, 0);

        // Second word arrives exactly on the timeout cycle: full pair.
        tick(0, 1, 32'h11, 0, 0);
        repeat (TIMEOUT - 1) tick(0, 0, 0, 0, 0);
        tick(0, 1, 32'h22, 0, 0);
        peek();
        chk("edge_level", 64'(level), 64'd1);
        chk("edge_data", out_data, 64'h00000022_00000011);
        chk("edge_half", 64'(out_half), 64'd0);
        repeat (TIMEOUT + 2) tick(0, 0, 0, 0, 0);
        peek();
        chk("edge_no_half", 64'(level), 64'd1);
        tick(0, 0, 0, 1, 0);

        // Overfill with ready low.
        for (int i = 1; i <= 2 * DEPTH + 2; i++) tick(0, 1, 32'(i), 0, 0);
        peek();
        chk("fill_level", 64'(level), 64'(DEPTH));
        chk("fill_ovf", 64'(overflow), 64'd1);
        chk("fill_head", out_data, 64'h00000002_00000001);
        tick(0, 0, 0, 0, 1);
        peek();
        chk("ovf_clr", 64'(overflow), 64'd0);

        // Full FIFO: push alongside a pop is accepted.
        tick(0, 1, 32'h100, 0, 0);
        tick(0, 1, 32'h200, 1, 0);
        peek();
        chk("fullpp_level", 64'(level), 64'(DEPTH));
        chk("fullpp_ovf", 64'(overflow), 64'd0);
        chk("fullpp_head", out_data, 64'h00000004_00000003);
        repeat (DEPTH + 2) tick(0, 0, 0, 1, 0);

        // Reset while holding a low word and three entries.
        for (int i = 0; i < 7; i++) tick(0, 1, 32'h40 + 32'(i), 0, 0);
        tick(1, 0, 0, 0, 0);
        peek();
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        tick(0, 1, 32'h77, 0, 0);
        tick(0, 1, 32'h88, 0, 0);
        peek();
        chk("rst_newpair", out_data, 64'h00000088_00000077);
        tick(0, 0, 0, 1, 0);

        // Randomized phases with varying input density and backpressure.
        for (int p = 0; p < 12; p++) begin
            int en_pct;
            int rdy_pct;
            en_pct  = $urandom_range(2, 90);
            rdy_pct = $urandom_range(5, 95);
            for (int c = 0; c < 300; c++) begin
                tick(($urandom_range(0, 999) == 0),
                     ($urandom_range(0, 99) < en_pct),
                     $urandom,
                     ($urandom_range(0, 99) < rdy_pct),
                     ($urandom_range(0, 49) == 0));
            end
        end
        tick(0, 0, 0, 0, 0);
        @(negedge clk2);
        check_all();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
